sdram_ctrl_iface_gen2: RTL and testbench
========================================

SDRAM_CTRL_IFACE_GEN2 -- requirements
Module: sdram_ctrl_iface_gen2

Interface
REQ-001 SHALL have parameter ASIZE, default 22, address width.
REQ-002 SHALL have parameter REF_PER, default 1562, clocks between refresh ticks (>=2).
REQ-003 SHALL have parameter INIT_PER, default 10000, power-up wait clocks (>=1).
REQ-004 SHALL have parameter INIT_REFS, default 8, init auto-refresh count (1..255).
REQ-005 SHALL have parameter REF_GAP, default 20, clocks between init command pulses (>=2).
REQ-006 SHALL have parameter MAX_PEND, default 4, max outstanding refreshes (1..15).
REQ-007 SHALL have ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- CMD  in  3  host command: 000 NOP, 001 READA, 010 WRITEA, 100 LOAD_MODE, others NOP.
- ADDR  in  ASIZE  host address.
- REF_ACK  in  1  refresh issued, one-cycle pulse.
- CM_ACK  in  1  command-engine acknowledge.
- NOP, READA, WRITEA  out  1 each  registered decode.
- REFRESH, PRECHARGE, LOAD_MODE  out  1 each  one-cycle command pulses.
- SADDR  out  ASIZE  registered ADDR.
- REF_REQ  out  1  refresh wanted.
- REF_PEND  out  4  outstanding refresh count.
- INIT_REQ  out  1  high during power-up wait.
- INIT_DONE  out  1  init sequence complete.
- CMD_ACK  out  1  host acknowledge pulse.

Function
REQ-008 Init FSM SHALL use states WAIT, PRE, REF, LMR, RUN; reset enters WAIT with init counter 0.
REQ-009 WAIT: INIT_REQ=1; counter increments each clock; exit to PRE when counter reaches INIT_PER-1.
REQ-010 PRE: PRECHARGE pulses 1 clock on entry; REF_GAP clocks later, go to REF.
REQ-011 REF: REFRESH pulses on entry and every REF_GAP clocks, INIT_REFS pulses total; REF_GAP clocks after last pulse, go to LMR.
REQ-012 LMR: LOAD_MODE pulses 1 clock on entry; next clock go to RUN; INIT_DONE=1 from RUN onward.
REQ-013 Before RUN, NOP=1, READA=WRITEA=0, host LOAD_MODE ignored, CMD_ACK held 0.
REQ-014 In RUN, every clock: SADDR<=ADDR; NOP/READA/WRITEA<=decode of CMD; LOAD_MODE<=(CMD==100); latency 1 clock.
REQ-015 CMD_ACK SHALL be 1 in the clock after CM_ACK=1 while CMD_ACK=0, else 0 (max one pulse per two clocks).
REQ-016 Refresh timer SHALL count down from REF_PER-1 only in RUN, tick at 0 and reload REF_PER-1.
REQ-017 Tick SHALL increment REF_PEND, saturating at MAX_PEND; REF_ACK with REF_PEND>0 decrements; simultaneous tick and REF_ACK leaves REF_PEND unchanged (saturation included); REF_ACK at 0 ignored.
REQ-018 REF_REQ SHALL be (REF_PEND!=0) AND INIT_DONE, combinational from registers.
REQ-019 REF_ACK before RUN SHALL be ignored.

Reset
REQ-020 RESET_N low SHALL immediately clear all outputs, counters, and REF_PEND to 0, except NOP=1 and INIT_REQ=1; FSM to WAIT.
REQ-021 Reset mid-sequence (any state) SHALL restart the full init sequence from WAIT.

Configuration
REQ-022 With SDRAM_REF_OVF_EN defined: 1-bit output REF_OVF, set sticky when a tick occurs with REF_PEND==MAX_PEND and no REF_ACK, cleared only by reset; without it: port absent, saturation silent.

Verification (INIT_PER=10, INIT_REFS=2, REF_GAP=4, REF_PER=16, MAX_PEND=2)
REQ-023 Release reset at cycle 0 -> INIT_REQ high cycles 0-9; PRECHARGE at 10; REFRESH at 14, 18; LOAD_MODE at 22; INIT_DONE from 23.
REQ-024 RUN, CMD=001 ADDR=0x1234 -> next clock READA=1, NOP=0, SADDR=0x1234; CMD=110 -> NOP=1.
REQ-025 RUN, no REF_ACK for 48 clocks -> REF_PEND 1,2,2; REF_OVF=1 (macro on); REF_ACK then -> REF_PEND=1.
REQ-026 REF_ACK coincident with tick at REF_PEND=1 -> REF_PEND stays 1, REF_REQ stays 1.
REQ-027 CM_ACK held high 4 clocks -> CMD_ACK pattern 1,0,1,0.
REQ-028 RESET_N pulsed low during REF state -> outputs reset asynchronously; sequence restarts, PRECHARGE 10 clocks after release.

Source files
------------

// File: rtl/sdram_ctrl_iface_gen2.sv
// SDRAM host-interface front end: power-up init sequencer, registered command decode and refresh bookkeeping.
// Optional macro SDRAM_REF_OVF_EN adds the sticky REF_OVF refresh-overflow flag.
module sdram_ctrl_iface_gen2 #(
    parameter int ASIZE     = 22,
    parameter int REF_PER   = 1562,
    parameter int INIT_PER  = 10000,
    parameter int INIT_REFS = 8,
    parameter int REF_GAP   = 20,
    parameter int MAX_PEND  = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [2:0]       CMD,
    input  logic [ASIZE-1:0] ADDR,
    input  logic             REF_ACK,
    input  logic             CM_ACK,
    output logic             NOP,
    output logic             READA,
    output logic             WRITEA,
    output logic             REFRESH,
    output logic             PRECHARGE,
    output logic             LOAD_MODE,
    output logic [ASIZE-1:0] SADDR,
    output logic             REF_REQ,
    output logic [3:0]       REF_PEND,
    output logic             INIT_REQ,
    output logic             INIT_DONE,
    output logic             CMD_ACK
`ifdef SDRAM_REF_OVF_EN
    ,
    output logic             REF_OVF
`endif
);

    localparam int CNT_MAX = (INIT_PER > REF_GAP) ? INIT_PER : REF_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(REF_PER + 1);

    typedef enum logic [2:0] {ST_WAIT, ST_PRE, ST_REF, ST_LMR, ST_RUN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [7:0]       refs_reg, refs_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [3:0]       pend_reg, pend_next;
    logic             pre_next, ref_next, lmr_next;
    logic             nop_reg, reada_reg, writea_reg;
    logic             refresh_reg, precharge_reg, load_mode_reg, cmd_ack_reg;
    logic [ASIZE-1:0] saddr_reg;
    logic             run, tick, ack_ok;

    assign run    = (state_reg == ST_RUN);
    assign tick   = run && (timer_reg == '0);
    assign ack_ok = run && REF_ACK && (pend_reg != 4'd0);

    // Init sequencer: cnt_reg measures the power-up wait, then the gap between command pulses.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        refs_next  = refs_reg;
        pre_next   = 1'b0;
        ref_next   = 1'b0;
        lmr_next   = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (cnt_reg == CW'(INIT_PER - 1)) begin
                    state_next = ST_PRE;
                    cnt_next   = '0;
                    pre_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt_reg == CW'(REF_GAP - 1)) begin
                    state_next = ST_REF;
                    cnt_next   = '0;
                    ref_next   = 1'b1;
                    refs_next  = 8'd1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_REF: begin
                if (cnt_reg == CW'(REF_GAP - 1)) begin
                    cnt_next = '0;
                    if (refs_reg == 8'(INIT_REFS)) begin
                        state_next = ST_LMR;
                        lmr_next   = 1'b1;
                    end else begin
                        ref_next  = 1'b1;
                        refs_next = refs_reg + 8'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LMR:  state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_WAIT;
        endcase
    end

    // Refresh interval timer and pending-refresh counter; a tick and an ack cancel out.
    always_comb begin
        timer_next = timer_reg - 1'b1;
        if (!run || tick)
            timer_next = TW'(REF_PER - 1);
        pend_next = pend_reg;
        if (tick && !ack_ok) begin
            if (pend_reg != 4'(MAX_PEND))
                pend_next = pend_reg + 4'd1;
        end else if (ack_ok && !tick) begin
            pend_next = pend_reg - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_WAIT;
            cnt_reg       <= '0;
            refs_reg      <= 8'd0;
            timer_reg     <= '0;
            pend_reg      <= 4'd0;
            nop_reg       <= 1'b1;
            reada_reg     <= 1'b0;
            writea_reg    <= 1'b0;
            refresh_reg   <= 1'b0;
            precharge_reg <= 1'b0;
            load_mode_reg <= 1'b0;
            saddr_reg     <= '0;
            cmd_ack_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            refs_reg      <= refs_next;
            timer_reg     <= timer_next;
            pend_reg      <= pend_next;
            refresh_reg   <= ref_next;
            precharge_reg <= pre_next;
            nop_reg       <= !run || !(CMD == 3'b001 || CMD == 3'b010 || CMD == 3'b100);
            reada_reg     <= run && (CMD == 3'b001);
            writea_reg    <= run && (CMD == 3'b010);
            load_mode_reg <= lmr_next || (run && CMD == 3'b100);
            cmd_ack_reg   <= run && CM_ACK && !cmd_ack_reg;
            if (run)
                saddr_reg <= ADDR;
        end
    end

`ifdef SDRAM_REF_OVF_EN
    logic ovf_reg;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            ovf_reg <= 1'b0;
        else if (tick && !REF_ACK && pend_reg == 4'(MAX_PEND))
            ovf_reg <= 1'b1;
    end
    assign REF_OVF = ovf_reg;
`endif

    assign NOP       = nop_reg;
    assign READA     = reada_reg;
    assign WRITEA    = writea_reg;
    assign REFRESH   = refresh_reg;
    assign PRECHARGE = precharge_reg;
    assign LOAD_MODE = load_mode_reg;
    assign SADDR     = saddr_reg;
    assign CMD_ACK   = cmd_ack_reg;
    assign REF_PEND  = pend_reg;
    assign INIT_REQ  = (state_reg == ST_WAIT);
    assign INIT_DONE = run;
    assign REF_REQ   = (pend_reg != 4'd0) && run;

endmodule

// File: tb/tb_sdram_ctrl_iface_gen2.sv
// Directed bench for sdram_ctrl_iface_gen2: init timeline, host decode via scoreboard, refresh accounting, async reset.
module tb_sdram_ctrl_iface_gen2;

    localparam int ASIZE = 22;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [2:0]       CMD = 3'b000;
    logic [ASIZE-1:0] ADDR = '0;
    logic             REF_ACK = 1'b0;
    logic             CM_ACK = 1'b0;
    logic             NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE;
    logic [ASIZE-1:0] SADDR;
    logic             REF_REQ, INIT_REQ, INIT_DONE, CMD_ACK;
    logic [3:0]       REF_PEND;
`ifdef SDRAM_REF_OVF_EN
    logic             REF_OVF;
`endif

    sdram_ctrl_iface_gen2 #(
        .ASIZE(ASIZE), .REF_PER(16), .INIT_PER(10), .INIT_REFS(2), .REF_GAP(4), .MAX_PEND(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .REF_ACK(REF_ACK), .CM_ACK(CM_ACK),
        .NOP(NOP), .READA(READA), .WRITEA(WRITEA), .REFRESH(REFRESH), .PRECHARGE(PRECHARGE),
        .LOAD_MODE(LOAD_MODE), .SADDR(SADDR), .REF_REQ(REF_REQ), .REF_PEND(REF_PEND),
        .INIT_REQ(INIT_REQ), .INIT_DONE(INIT_DONE), .CMD_ACK(CMD_ACK)
`ifdef SDRAM_REF_OVF_EN
        , .REF_OVF(REF_OVF)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             reada;
        logic             writea;
        logic             nop;
        logic             load_mode;
        logic [ASIZE-1:0] saddr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   c = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        c++;
    endtask

    task automatic drive(input logic [2:0] cmd, input logic [ASIZE-1:0] addr);
        exp_t e;
        CMD  = cmd;
        ADDR = addr;
        e.reada     = (cmd == 3'b001);
        e.writea    = (cmd == 3'b010);
        e.load_mode = (cmd == 3'b100);
        e.nop       = !(e.reada || e.writea || e.load_mode);
        e.saddr     = addr;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("host_reada", 32'(READA), 32'(e.reada));
            check("host_writea", 32'(WRITEA), 32'(e.writea));
            check("host_nop", 32'(NOP), 32'(e.nop));
            check("host_load_mode", 32'(LOAD_MODE), 32'(e.load_mode));
            check("host_saddr", 32'(SADDR), 32'(e.saddr));
        end
    endtask

    task automatic check_pend(input int exp);
        check("ref_pend", 32'(REF_PEND), 32'(exp));
        check("ref_req", 32'(REF_REQ), 32'(exp != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_nop", 32'(NOP), 32'd1);
        check("rst_init_req", 32'(INIT_REQ), 32'd1);
        check("rst_init_done", 32'(INIT_DONE), 32'd0);
        check("rst_ref_pend", 32'(REF_PEND), 32'd0);
        check("rst_cmd_ack", 32'(CMD_ACK), 32'd0);
        check("rst_saddr", 32'(SADDR), 32'd0);

        // Init timeline, with host activity that must be ignored
        CMD = 3'b100; ADDR = 22'h15A5A; CM_ACK = 1'b1; REF_ACK = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        c = 0;
        forever begin
            check("init_req", 32'(INIT_REQ), 32'(c <= 9));
            check("init_precharge", 32'(PRECHARGE), 32'(c == 10));
            check("init_refresh", 32'(REFRESH), 32'(c == 14 || c == 18));
            check("init_load_mode", 32'(LOAD_MODE), 32'(c == 22));
            check("init_done", 32'(INIT_DONE), 32'(c >= 23));
            check("init_nop", 32'(NOP), 32'd1);
            check("init_reada", 32'(READA), 32'd0);
            check("init_cmd_ack", 32'(CMD_ACK), 32'd0);
            check("init_ref_pend", 32'(REF_PEND), 32'd0);
            if (c == 23) break;
            step();
        end
        CM_ACK = 1'b0;
        REF_ACK = 1'b0;

        // Host command decode through the scoreboard
        drive(3'b001, 22'h01234); step(); pop_check();
        drive(3'b110, 22'h3FFFFF); step(); pop_check();
        drive(3'b010, 22'h2ABCD); step(); pop_check();
        drive(3'b100, 22'h00055); step(); pop_check();
        drive(3'b111, 22'h00000); step(); pop_check();
        drive(3'b000, 22'h1FFFF); step(); pop_check();
        CMD = 3'b000;

        // CM_ACK held high four clocks
        CM_ACK = 1'b1;
        step(); check("cmd_ack_1", 32'(CMD_ACK), 32'd1);
        step(); check("cmd_ack_2", 32'(CMD_ACK), 32'd0);
        step(); check("cmd_ack_3", 32'(CMD_ACK), 32'd1);
        step(); check("cmd_ack_4", 32'(CMD_ACK), 32'd0);
        CM_ACK = 1'b0;

        // Refresh ticks with no ack: first tick lands at cycle 39, then every 16
        while (c < 71) begin
            check_pend((c >= 55) ? 2 : (c >= 39) ? 1 : 0);
`ifdef SDRAM_REF_OVF_EN
            check("ref_ovf_clear", 32'(REF_OVF), 32'd0);
`endif
            step();
        end
        check_pend(2);
`ifdef SDRAM_REF_OVF_EN
        check("ref_ovf_set", 32'(REF_OVF), 32'd1);
`endif
        REF_ACK = 1'b1;
        step();
        REF_ACK = 1'b0;
        check_pend(1);

        // Ack coincident with the tick at cycle 86
        while (c < 86) begin
            step();
            check_pend(1);
        end
        REF_ACK = 1'b1;
        step(); check_pend(1);
        step(); check_pend(0);
        step(); check_pend(0);
        REF_ACK = 1'b0;

        // Asynchronous reset from RUN
        #1 RESET_N = 1'b0;
        #1;
        check("arst_init_done", 32'(INIT_DONE), 32'd0);
        check("arst_init_req", 32'(INIT_REQ), 32'd1);
`ifdef SDRAM_REF_OVF_EN
        check("arst_ref_ovf", 32'(REF_OVF), 32'd0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        c = 0;
        while (c < 14) step();
        check("ref_state_refresh", 32'(REFRESH), 32'd1);

        // Reset pulse during the REF state
        #1 RESET_N = 1'b0;
        #1;
        check("mid_refresh", 32'(REFRESH), 32'd0);
        check("mid_init_req", 32'(INIT_REQ), 32'd1);
        check("mid_nop", 32'(NOP), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        c = 0;
        forever begin
            check("restart_init_req", 32'(INIT_REQ), 32'(c <= 9));
            check("restart_precharge", 32'(PRECHARGE), 32'(c == 10));
            if (c == 10) break;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
